// File: rtl/ddr3_mem_cmd_ctrl.sv
//==============================================================================
// Module      : ddr3_mem_cmd_ctrl
// Description : Controller-side DDR3 command sequencer. Runs the power-up
//               NOP wait and ZQ calibration, then turns single CPU burst
//               requests (4 beats) into ACT / RD / WR / PRE sequences on the
//               SDRAM command bus.
//               Build option: define DDR3_OPEN_PAGE_EN to keep the row open
//               after each burst (open-page). Without it every burst is
//               followed by a PRE (close-page).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ddr3_mem_cmd_ctrl #(
  parameter int T_INIT = 8,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2,
  parameter int ROW_W  = 15,
  parameter int COL_W  = 6,
  parameter int DQ_W   = 16
) (
  input  logic                cpu_clk,
  input  logic                RESET_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ROW_W-1:0]    req_row,
  input  logic [COL_W-1:0]    req_col,
  input  logic [4*DQ_W-1:0]   req_wdata,
  output logic [4*DQ_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                init_done,
  output logic                CS_N,
  output logic                RAS_N,
  output logic                CAS_N,
  output logic                WE_N,
  output logic [ROW_W-1:0]    ADDR,
  output logic [COL_W-1:0]    COL,
  output logic [DQ_W-1:0]     WR_DATA,
  input  logic [DQ_W-1:0]     RD_DATA
);

  // Command encodings {CS_N,RAS_N,CAS_N,WE_N}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ZQC = 4'b0110;

  // One shared down-time counter must hold the largest wait value
  localparam int CNT_MAX = (T_INIT > T_RCD) ? ((T_INIT > T_RP) ? T_INIT : T_RP)
                                            : ((T_RCD  > T_RP) ? T_RCD  : T_RP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // State names describe what the current cycle is doing on the bus
  typedef enum logic [3:0] {
    ST_INIT_WAIT = 4'd0,
    ST_ZQ        = 4'd1,
    ST_IDLE      = 4'd2,
    ST_ACT       = 4'd3,
    ST_RCD_WAIT  = 4'd4,
    ST_OPEN      = 4'd5,
    ST_RD_BURST  = 4'd6,
    ST_WR_BURST  = 4'd7,
    ST_PRE       = 4'd8,
    ST_RP_WAIT   = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          ph_q, ph_d;          // 0 = command cycle, 1..4 = beats 0..3
  logic                we_q, we_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [4*DQ_W-1:0]   wdata_q, wdata_d;
  logic                pend_q, pend_d;      // row-miss ACT owed after RP_WAIT
  logic [3:0]          cmd_q, cmd_d;
  logic [ROW_W-1:0]    addr_q, addr_d;
  logic [COL_W-1:0]    bus_col_q, bus_col_d;
  logic [DQ_W-1:0]     wr_data_q, wr_data_d;
  logic [3*DQ_W-1:0]   rd_buf_q, rd_buf_d;
  logic [4*DQ_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                init_done_q, init_done_d;
  logic [1:0]          beat_lo;

  // Column of the beat following the current phase, wrapping inside the aligned 4
  assign beat_lo = col_q[1:0] + ph_q[1:0];

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign ADDR      = addr_q;
  assign COL       = bus_col_q;
  assign WR_DATA   = wr_data_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_done = init_done_q;

`ifdef DDR3_OPEN_PAGE_EN
  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_OPEN);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif

  // Next-state, next-command and datapath decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    we_d        = we_q;
    row_d       = row_q;
    col_d       = col_q;
    wdata_d     = wdata_q;
    pend_d      = pend_q;
    cmd_d       = CMD_NOP;
    addr_d      = addr_q;
    bus_col_d   = bus_col_q;
    wr_data_d   = '0;
    rd_buf_d    = rd_buf_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    init_done_d = init_done_q;

    case (state_q)
      ST_INIT_WAIT: begin
        if (cnt_q == CNT_W'(T_INIT)) begin
          cmd_d   = CMD_ZQC;
          cnt_d   = '0;
          state_d = ST_ZQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ZQ: begin
        init_done_d = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          row_d   = req_row;
          col_d   = req_col;
          wdata_d = req_wdata;
          cmd_d   = CMD_ACT;
          addr_d  = req_row;
          state_d = ST_ACT;
        end
      end

      ST_ACT: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_RCD_WAIT;
      end

      ST_RCD_WAIT: begin
        if (cnt_q == CNT_W'(T_RCD - 1)) begin
          cmd_d     = we_q ? CMD_WR : CMD_RD;
          bus_col_d = col_q;
          ph_d      = 3'd0;
          state_d   = we_q ? ST_WR_BURST : ST_RD_BURST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_OPEN: begin
`ifdef DDR3_OPEN_PAGE_EN
        if (req_valid) begin
          we_d    = req_we;
          row_d   = req_row;
          col_d   = req_col;
          wdata_d = req_wdata;
          if (req_row == addr_q) begin
            // Row hit: column command goes straight out
            cmd_d     = req_we ? CMD_WR : CMD_RD;
            bus_col_d = req_col;
            ph_d      = 3'd0;
            state_d   = req_we ? ST_WR_BURST : ST_RD_BURST;
          end else begin
            // Row miss: close the open row, ACT the new one after tRP
            cmd_d   = CMD_PRE;
            pend_d  = 1'b1;
            state_d = ST_PRE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_RD_BURST, ST_WR_BURST: begin
        ph_d = ph_q + 3'd1;
        if (ph_q != 3'd4) begin
          bus_col_d = {col_q[COL_W-1:2], beat_lo};
          if (state_q == ST_WR_BURST) begin
            for (int k = 0; k < 4; k++) begin
              if (ph_q == 3'(k)) wr_data_d = wdata_q[k*DQ_W +: DQ_W];
            end
          end
        end
        if (state_q == ST_RD_BURST) begin
          for (int k = 0; k < 3; k++) begin
            if (ph_q == 3'(k + 1)) rd_buf_d[k*DQ_W +: DQ_W] = RD_DATA;
          end
        end
        if (ph_q == 3'd4) begin
          if (state_q == ST_RD_BURST) begin
            rd_data_d  = {RD_DATA, rd_buf_q};
            rd_valid_d = 1'b1;
          end
`ifdef DDR3_OPEN_PAGE_EN
          state_d = ST_OPEN;
`else
          cmd_d   = CMD_PRE;
          state_d = ST_PRE;
`endif
        end
      end

      ST_PRE: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_RP_WAIT;
      end

      ST_RP_WAIT: begin
        if (cnt_q == CNT_W'(T_RP - 1)) begin
          if (pend_q) begin
            cmd_d   = CMD_ACT;
            addr_d  = row_q;
            pend_d  = 1'b0;
            state_d = ST_ACT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_INIT_WAIT;
    endcase
  end

  // State, request and output registers; async reset drops any transfer in flight
  always_ff @(posedge cpu_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_INIT_WAIT;
      cnt_q       <= '0;
      ph_q        <= '0;
      we_q        <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      wdata_q     <= '0;
      pend_q      <= 1'b0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      bus_col_q   <= '0;
      wr_data_q   <= '0;
      rd_buf_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      we_q        <= we_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wdata_q     <= wdata_d;
      pend_q      <= pend_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      bus_col_q   <= bus_col_d;
      wr_data_q   <= wr_data_d;
      rd_buf_q    <= rd_buf_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      init_done_q <= init_done_d;
    end
  end

endmodule

`default_nettype wire
